dm_arbiter: RTL

//  Shares one single-port data-memory SRAM between two AHB-style requesters: M0 (CPU data port) and M1 (DMA).

---
 rtl/dm_arb_pkg.sv | 54 +++++
 rtl/dm_rr_pick.sv | 15 +
 rtl/dm_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Provides the FSM state enum, AHB size codes and byte-lane/alignment helpers.
`ifndef AHB_SIZE_BYTE
`define AHB_SIZE_BYTE 3'b000
`endif
`ifndef AHB_SIZE_HWORD
`define AHB_SIZE_HWORD 3'b001
`endif
`ifndef AHB_SIZE_WORD
`define AHB_SIZE_WORD 3'b010
`endif

package dm_arb_pkg;

    localparam logic [2:0] SZ_BYTE  = `AHB_SIZE_BYTE;
    localparam logic [2:0] SZ_HWORD = `AHB_SIZE_HWORD;
    localparam logic [2:0] SZ_WORD  = `AHB_SIZE_WORD;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Active-high lane mask for an access of size typ at byte offset a.
    function automatic logic [3:0] be_of(input logic [2:0] typ,
                                         input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (typ)
            SZ_BYTE:  be = 4'b0001 << a;
            SZ_HWORD: be = a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD:  be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

    // Oversized types count as misaligned so one check covers both.
    function automatic logic is_misaligned(input logic [2:0] typ,
                                           input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        if (typ > SZ_WORD)
            bad = 1'b1;
        else if (typ == SZ_HWORD)
            bad = a[0];
        else if (typ == SZ_WORD)
            bad = (a != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/dm_rr_pick.sv
// Two-way round-robin pick, purely combinational.
// Ports: req[1:0] requests, lg last grant; gnt chosen index, any = some request.
module dm_rr_pick
(
    input  logic [1:0] req,
    input  logic       lg,
    output logic       gnt,
    output logic       any
);

    assign any = |req;
    // On a tie the master that did not win last time goes first.
    assign gnt = (req == 2'b11) ? ~lg : req[1];

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port DM SRAM between M0 (CPU) and M1 (DMA).
// Ports: clk, rst (sync active-low); Mx_req/write/type/addr/wdata in, Mx_rdata/wait/err out;
// DM_CS/OE/WEB/A/DI to SRAM, DM_DO from SRAM. Optional macro DM_ARB_STALL_CNT_EN
// adds M0_stall_cnt/M1_stall_cnt saturating stall counters.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int          DATA_BITS = 32,
    parameter int          DM_ADDR_W = 14,
    parameter logic [15:0] DM_BASE   = 16'h0001
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 M0_req,
    input  logic                 M0_write,
    input  logic [2:0]           M0_type,
    input  logic [DATA_BITS-1:0] M0_addr,
    input  logic [DATA_BITS-1:0] M0_wdata,
    output logic [DATA_BITS-1:0] M0_rdata,
    output logic                 M0_wait,
    output logic                 M0_err,
    input  logic                 M1_req,
    input  logic                 M1_write,
    input  logic [2:0]           M1_type,
    input  logic [DATA_BITS-1:0] M1_addr,
    input  logic [DATA_BITS-1:0] M1_wdata,
    output logic [DATA_BITS-1:0] M1_rdata,
    output logic                 M1_wait,
    output logic                 M1_err,
    output logic                 DM_CS,
    output logic                 DM_OE,
    output logic [3:0]           DM_WEB,
    output logic [DM_ADDR_W-1:0] DM_A,
    output logic [DATA_BITS-1:0] DM_DI,
    input  logic [DATA_BITS-1:0] DM_DO
`ifdef DM_ARB_STALL_CNT_EN
    ,
    output logic [15:0]          M0_stall_cnt,
    output logic [15:0]          M1_stall_cnt
`endif
);

    state_t state;
    logic   own;
    logic   lg;
    logic   gnt;
    logic   any;

    dm_rr_pick u_pick (
        .req ({M1_req, M0_req}),
        .lg  (lg),
        .gnt (gnt),
        .any (any)
    );

    // Candidate request, checked before any SRAM cycle is started.
    logic [2:0]  win_type;
    logic [1:0]  win_lo;
    logic [15:0] win_hi;
    logic        reject;

    assign win_type = gnt ? M1_type : M0_type;
    assign win_lo   = gnt ? M1_addr[1:0] : M0_addr[1:0];
    assign win_hi   = gnt ? M1_addr[DATA_BITS-1:16]
                          : M0_addr[DATA_BITS-1:16];
    assign reject   = is_misaligned(win_type, win_lo) |
                      (win_hi != DM_BASE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            own   <= 1'b0;
            lg    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        own   <= gnt;
                        lg    <= gnt;
                        state <= reject ? ST_ERR : ST_ACCESS;
                    end
                end
                ST_ACCESS: state <= ST_DONE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Owner's request fields; masters hold them stable while stalled.
    logic                 sel_write;
    logic [2:0]           sel_type;
    logic [DM_ADDR_W+1:0] sel_lo;
    logic [DATA_BITS-1:0] sel_wdata;

    assign sel_write = own ? M1_write : M0_write;
    assign sel_type  = own ? M1_type  : M0_type;
    assign sel_lo    = own ? M1_addr[DM_ADDR_W+1:0]
                           : M0_addr[DM_ADDR_W+1:0];
    assign sel_wdata = own ? M1_wdata : M0_wdata;

    always_comb begin
        DM_CS  = 1'b0;
        DM_OE  = 1'b0;
        DM_WEB = 4'hF;
        DM_A   = '0;
        DM_DI  = '0;
        if (state == ST_ACCESS) begin
            DM_CS = 1'b1;
            DM_A  = sel_lo[DM_ADDR_W+1:2];
            DM_DI = sel_wdata;
            if (sel_write)
                DM_WEB = ~be_of(sel_type, sel_lo[1:0]);
            else
                DM_OE = 1'b1;
        end
    end

    // Completion only reaches a master still requesting; held in reset
    // so a stalled master keeps waiting until re-arbitrated.
    logic fin;
    logic is_err;
    logic c0;
    logic c1;

    assign fin    = rst & ((state == ST_DONE) | (state == ST_ERR));
    assign is_err = (state == ST_ERR);
    assign c0     = fin & ~own & M0_req;
    assign c1     = fin &  own & M1_req;

    assign M0_wait  = M0_req & ~c0;
    assign M1_wait  = M1_req & ~c1;
    assign M0_err   = c0 & is_err;
    assign M1_err   = c1 & is_err;
    assign M0_rdata = (c0 & ~is_err & ~M0_write) ? DM_DO : '0;
    assign M1_rdata = (c1 & ~is_err & ~M1_write) ? DM_DO : '0;

`ifdef DM_ARB_STALL_CNT_EN
    logic stall0;
    logic stall1;

    assign stall0 = M0_req & M0_wait & (state != ST_IDLE) &  own;
    assign stall1 = M1_req & M1_wait & (state != ST_IDLE) & ~own;

    always_ff @(posedge clk) begin
        if (!rst) begin
            M0_stall_cnt <= 16'h0000;
            M1_stall_cnt <= 16'h0000;
        end else begin
            if (stall0 && (M0_stall_cnt != 16'hFFFF))
                M0_stall_cnt <= M0_stall_cnt + 16'h0001;
            if (stall1 && (M1_stall_cnt != 16'hFFFF))
                M1_stall_cnt <= M1_stall_cnt + 16'h0001;
        end
    end
`endif

endmodule
